// File: rtl/alu_exec_if.sv
// alu_exec_if: request/response bundle between the pipeline controller and alu_exec.
// The master drives start/op/operands; the slave (alu_exec) returns results and status.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  result, zero, hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output result, zero, hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU; single-cycle AND/OR/ADD/SUB/SLT/NOP, iterative MULT/DIV into HI/LO.
// Define ALU_SIGNED_MULDIV_EN for two's-complement MULT/DIV; the default build is unsigned.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_DIV  = 3'b101;
  localparam logic [2:0] OP_MULT = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d, dz_q, dz_d;
  logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic               zero_q, zero_d, busy_q, busy_d, done_q, done_d, divz_q, divz_d;

  logic [WIDTH-1:0]        alu_res, a_m, b_m, fix_hi, fix_lo;
  logic [WIDTH:0]          sum, shifted, trial;
  logic [2*WIDTH-1:0]      prod_fix;
  logic signed [WIDTH-1:0] a_s, b_s;

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  always_comb begin
    alu_res = '0;
    a_s     = bus.a;
    b_s     = bus.b;
    case (bus.op)
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_ADD:  alu_res = bus.a + bus.b;
      OP_SUB:  alu_res = bus.a - bus.b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    result_d = result_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    divz_d   = divz_q;
    a_m      = bus.a;
    b_m      = bus.b;
    sum      = '0;
    shifted  = '0;
    trial    = '0;
    fix_hi   = acc_q[2*WIDTH-1:WIDTH];
    fix_lo   = acc_q[WIDTH-1:0];
    prod_fix = acc_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          divz_d = 1'b0;
          if (bus.op == OP_MULT || bus.op == OP_DIV) begin
`ifdef ALU_SIGNED_MULDIV_EN
            a_m      = cneg(bus.a, bus.a[WIDTH-1]);
            b_m      = cneg(bus.b, bus.b[WIDTH-1]);
            neg_lo_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            neg_hi_d = bus.a[WIDTH-1];
`else
            neg_lo_d = 1'b0;
            neg_hi_d = 1'b0;
`endif
            busy_d   = 1'b1;
            cnt_d    = CNT_W'(WIDTH);
            is_div_d = (bus.op == OP_DIV);
            dz_d     = 1'b0;
            state_d  = RUN;
            if (bus.op == OP_DIV && bus.b == '0) begin
              // Divide-by-zero skips the iterations; FIX publishes hi=a, lo=all ones.
              dz_d    = 1'b1;
              acc_d   = {bus.a, {WIDTH{1'b1}}};
              cnt_d   = '0;
              state_d = FIX;
            end else if (bus.op == OP_DIV) begin
              acc_d  = {{WIDTH{1'b0}}, a_m};
              opnd_d = b_m;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, b_m};
              opnd_d = a_m;
            end
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
          end
        end
      end

      RUN: begin
        if (is_div_q) begin
          // Restoring step: upper half is the partial remainder, lower half shifts in quotient bits.
          shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
          trial   = shifted - {1'b0, opnd_q};
          if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else               acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end

      FIX: begin
        if (!dz_q) begin
          if (is_div_q) begin
            fix_lo = cneg(acc_q[WIDTH-1:0], neg_lo_q);
            fix_hi = cneg(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
          end else begin
            prod_fix = cneg2(acc_q, neg_lo_q);
            fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo   = prod_fix[WIDTH-1:0];
          end
        end
        hi_d     = fix_hi;
        lo_d     = fix_lo;
        result_d = fix_lo;
        zero_d   = (fix_lo == '0);
        divz_d   = dz_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        cnt_d    = '0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      divz_q   <= divz_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = divz_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed-vector bench for alu_exec with a queue scoreboard drained by a done monitor.
// Expected MULT/DIV values follow ALU_SIGNED_MULDIV_EN as the design does.
module tb_alu_exec;
  localparam int W = 32;
  localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, ADD_ = 3'b010, SUB_ = 3'b011;
  localparam logic [2:0] SLT_ = 3'b100, DIV_ = 3'b101, NOP_ = 3'b110, MULT_ = 3'b111;

  typedef struct {
    string        nm;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         zero;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(W)) bus ();
  alu_exec #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t         sbq[$];
  exp_t         mon_e;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           last_acc = 0;
  int           acc0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [W-1:0] r, input logic dz);
    exp_t e;
    e.nm = nm; e.res = r; e.hi = m_hi; e.lo = m_lo; e.zero = (r == '0); e.dz = dz;
    sbq.push_back(e);
  endtask

  task automatic push_hl(input string nm, input logic [W-1:0] h, input logic [W-1:0] l,
                         input logic dz);
    m_hi = h;
    m_lo = l;
    push(nm, l, dz);
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(posedge clk);
    #1;
    last_acc  = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int acc, input int exp_lat);
    int n;
    n = 0;
    while (!bus.done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end else begin
      chk({nm, "_latency"}, cyc - acc, exp_lat);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_result"},   bus.result, '0);
    chk({tag, "_hi"},       bus.hi, '0);
    chk({tag, "_lo"},       bus.lo, '0);
    chk({tag, "_zero"},     {31'b0, bus.zero}, '0);
    chk({tag, "_busy"},     {31'b0, bus.busy}, '0);
    chk({tag, "_done"},     {31'b0, bus.done}, '0);
    chk({tag, "_div_zero"}, {31'b0, bus.div_zero}, '0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h required=no_done", bus.result);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.nm, "_result"},   bus.result, mon_e.res);
        chk({mon_e.nm, "_zero"},     {31'b0, bus.zero}, {31'b0, mon_e.zero});
        chk({mon_e.nm, "_div_zero"}, {31'b0, bus.div_zero}, {31'b0, mon_e.dz});
        chk({mon_e.nm, "_hi"},       bus.hi, mon_e.hi);
        chk({mon_e.nm, "_lo"},       bus.lo, mon_e.lo);
      end
    end
  end

  initial begin
    bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops
    push("and", 32'h0000_0008, 1'b0);  send(AND_, 32'h0000_000C, 32'h0000_000A);
    push("or",  32'h0000_000E, 1'b0);  send(OR_,  32'h0000_000C, 32'h0000_000A);
    push("sub", 32'h0000_0002, 1'b0);  send(SUB_, 32'h0000_000C, 32'h0000_000A);
    push("add", 32'h0000_0016, 1'b0);  send(ADD_, 32'h0000_000C, 32'h0000_000A);
    push("slt_neg", 32'h0000_0001, 1'b0); send(SLT_, 32'hFFFF_FFFF, 32'h0000_0001);
    push("slt_pos", 32'h0000_0000, 1'b0); send(SLT_, 32'h0000_0001, 32'hFFFF_FFFF);
    push("add_wrap", 32'h0000_0000, 1'b0); send(ADD_, 32'hFFFF_FFFF, 32'h0000_0001);
    push("nop", 32'h0000_0000, 1'b0);  send(NOP_, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done("nop", last_acc, 0);
    repeat (2) @(posedge clk);
    #1;

`ifdef ALU_SIGNED_MULDIV_EN
    push_hl("mult_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
`else
    push_hl("mult_m3x5", 32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
`endif
    send(MULT_, 32'hFFFF_FFFD, 32'h0000_0005);
    acc0 = last_acc;
    chk("mult_busy_after_accept", {31'b0, bus.busy}, 32'h1);
    wait_done("mult_m3x5", acc0, 33);
    chk("mult_busy_in_done", {31'b0, bus.busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("mult_lo_hold", bus.lo, m_lo);

`ifdef ALU_SIGNED_MULDIV_EN
    push_hl("div_m7by2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
`else
    push_hl("div_m7by2", 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
`endif
    send(DIV_, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("div_m7by2", last_acc, 33);

    push_hl("div_100by7", 32'd2, 32'd14, 1'b0);
    send(DIV_, 32'd100, 32'd7);
    wait_done("div_100by7", last_acc, 33);

`ifdef ALU_SIGNED_MULDIV_EN
    push_hl("div_7bym2", 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
`else
    push_hl("div_7bym2", 32'h0000_0007, 32'h0000_0000, 1'b0);
`endif
    send(DIV_, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_7bym2", last_acc, 33);

    // Divide by zero, then confirm the flag clears on the next accepted start
    push_hl("div_zero", 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    send(DIV_, 32'h1234_5678, 32'h0000_0000);
    wait_done("div_zero", last_acc, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("div_zero_hold", {31'b0, bus.div_zero}, 32'h1);
    push("add_clears_dz", 32'h0000_0002, 1'b0);
    send(ADD_, 32'h1, 32'h1);
    wait_done("add_clears_dz", last_acc, 0);

    // Start while busy is ignored; start in the done cycle is accepted
    push_hl("mult_3x4", 32'h0, 32'd12, 1'b0);
    send(MULT_, 32'd3, 32'd4);
    acc0 = last_acc;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_mid_run", {31'b0, bus.busy}, 32'h1);
    send(ADD_, 32'h1, 32'h1);
    wait_done("mult_3x4", acc0, 33);
    push("add_in_done_cycle", 32'd11, 1'b0);
    send(ADD_, 32'd5, 32'd6);
    wait_done("add_in_done_cycle", last_acc, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset during RUN discards the MULT
    send(MULT_, 32'd7, 32'd6);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("reset_mid_run");
    m_hi = '0;
    m_lo = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push("add_after_reset", 32'd7, 1'b0);
    send(ADD_, 32'd3, 32'd4);
    wait_done("add_after_reset", last_acc, 0);

    repeat (40) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
